btn_event_gen: RTL

Converts debounced, synchronized push-button levels into discrete press, release, long-press and auto-repeat events. Events are delivered as a valid/ready stream. Sits between `debounce_switch` and `fpga_core` in the board top level, in the 125 MHz `clk` domain. Each button runs an independent hold-time state machine; a fixed-priority arbiter funnels events into a small output FIFO.

---
 rtl/btn_event_pkg.sv | 21 ++
 rtl/btn_event_unit.sv | 105 ++++++++++
 rtl/btn_event_gen.sv | 88 ++++++++
 3 files changed

// File: rtl/btn_event_pkg.sv
// Shared event codes, per-button FSM states and index-width helper for btn_event_gen.
package btn_event_pkg;

    typedef enum logic [1:0] {
        EV_PRESS   = 2'd0,
        EV_RELEASE = 2'd1,
        EV_LONG    = 2'd2,
        EV_REPEAT  = 2'd3
    } ev_type_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } btn_state_e;

    function automatic int idx_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/btn_event_unit.sv
// One button: edge detect, hold-time FSM and a one-entry pending event slot.
// Auto-repeat in HELD exists only when BTN_EVENT_REPEAT_EN is defined.
module btn_event_unit
    import btn_event_pkg::*;
#(
    parameter int LONG_CYCLES   = 125000000,
    parameter int REPEAT_CYCLES = 31250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_i,
    input  logic       pend_clear,
    output logic       pend_valid,
    output logic [1:0] pend_type,
    output logic       drop
);

    localparam int CNT_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef BTN_EVENT_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_q;
    logic             pend_valid_q, pend_valid_d;
    logic [1:0]       pend_type_q, pend_type_d;
    logic             emit, slot_busy;
    ev_type_e         ev;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        emit    = 1'b0;
        ev      = EV_PRESS;
        // Release beats any LONG/REPEAT falling due on the same cycle.
        if (prev_q && !btn_i) begin
            emit    = 1'b1;
            ev      = EV_RELEASE;
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (btn_i && !prev_q) begin
                        emit    = 1'b1;
                        ev      = EV_PRESS;
                        state_d = ST_PRESSED;
                        cnt_d   = '0;
                    end
                end
                ST_PRESSED: begin
                    if (cnt_q == LONG_LAST) begin
                        emit    = 1'b1;
                        ev      = EV_LONG;
                        state_d = ST_HELD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_HELD: begin
`ifdef BTN_EVENT_REPEAT_EN
                    if (cnt_q == REP_LAST) begin
                        emit  = 1'b1;
                        ev    = EV_REPEAT;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A slot drained by the arbiter this cycle is free for a new event.
    assign slot_busy    = pend_valid_q && !pend_clear;
    assign drop         = emit && slot_busy;
    assign pend_valid_d = slot_busy || emit;
    assign pend_type_d  = (emit && !slot_busy) ? ev : pend_type_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            prev_q       <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_type_q  <= 2'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prev_q       <= btn_i;
            pend_valid_q <= pend_valid_d;
            pend_type_q  <= pend_type_d;
        end
    end

    assign pend_valid = pend_valid_q;
    assign pend_type  = pend_type_q;

endmodule

// File: rtl/btn_event_gen.sv
// Button event generator: per-button units, fixed-priority arbiter, output FIFO.
// Define BTN_EVENT_REPEAT_EN to enable auto-repeat events while a button is held.
module btn_event_gen
    import btn_event_pkg::*;
#(
    parameter int  WIDTH         = 5,
    parameter int  LONG_CYCLES   = 125000000,
    parameter int  REPEAT_CYCLES = 31250000,
    parameter int  FIFO_DEPTH    = 4,
    localparam int IDX_W         = idx_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [IDX_W+1:0] m_event_tdata,
    output logic             m_event_tvalid,
    input  logic             m_event_tready,
    output logic             overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0]      pend_valid, pend_clear, drop;
    logic [WIDTH-1:0][1:0] pend_type;

    for (genvar g = 0; g < WIDTH; g++) begin : g_unit
        btn_event_unit #(
            .LONG_CYCLES  (LONG_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_unit (
            .clk       (clk),
            .rst       (rst),
            .btn_i     (in[g]),
            .pend_clear(pend_clear[g]),
            .pend_valid(pend_valid[g]),
            .pend_type (pend_type[g]),
            .drop      (drop[g])
        );
    end

    logic [IDX_W-1:0] sel;
    logic             sel_vld;

    // Lowest index wins: scan downward so the last hit is the smallest.
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pend_valid[i]) begin
                sel     = IDX_W'(i);
                sel_vld = 1'b1;
            end
        end
    end

    logic [IDX_W+1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             fifo_full, rd_en, wr_en, overflow_q;

    assign fifo_full  = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
    assign rd_en      = m_event_tvalid && m_event_tready;
    assign wr_en      = sel_vld && (!fifo_full || rd_en);
    assign pend_clear = wr_en ? (WIDTH'(1) << sel) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= {sel, pend_type[sel]};
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + (PTR_W + 1)'(wr_en) - (PTR_W + 1)'(rd_en);
            if (|drop) overflow_q <= 1'b1;
        end
    end

    assign m_event_tvalid = (count_q != '0);
    assign m_event_tdata  = mem_q[rd_ptr_q];
    assign overflow       = overflow_q;

endmodule
